// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: synchroniser, debounce filter, rise/fall pulses,
// per-channel event mode, sticky W1C pending flags and an OR-ed interrupt.
module edge_detect_multi #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [2*WIDTH-1:0]   mode_i,
  input  logic [WIDTH-1:0]     clear_i,
  output logic [WIDTH-1:0]     level_o,
  output logic [WIDTH-1:0]     rise_o,
  output logic [WIDTH-1:0]     fall_o,
  output logic [WIDTH-1:0]     pending_o,
  output logic                 irq_o
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]    r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pending;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= a_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // A level is accepted only after FILT_CYCLES consecutive mismatching cycles.
  always_comb begin
    w_toggle = '0;
    w_ev     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_toggle[k] = (w_s[k] != r_level[k]) && (r_cnt[k] == CNT_LAST);
      w_ev[k]     = (r_rise[k] & mode_i[2*k]) | (r_fall[k] & mode_i[2*k+1]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < WIDTH; k++) r_cnt[k] <= '0;
      r_level   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_pending <= '0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if ((w_s[k] == r_level[k]) || w_toggle[k]) r_cnt[k] <= '0;
        else                                       r_cnt[k] <= r_cnt[k] + CW'(1);
      end
      r_level   <= r_level ^ w_toggle;
      r_rise    <= w_toggle & ~r_level;
      r_fall    <= w_toggle & r_level;
      // Set dominates a simultaneous clear so no event is lost.
      r_pending <= (r_pending & ~clear_i) | w_ev;
    end
  end

  assign level_o   = r_level;
  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign pending_o = r_pending;
  assign irq_o     = |r_pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed and random checks of edge_detect_multi against a cycle model via a scoreboard queue.
module tb_edge_detect_multi;

  localparam int FILT = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] a_i;
  logic [7:0] mode_i;
  logic [3:0] clear_i;
  logic [3:0] level_o, rise_o, fall_o, pending_o;
  logic       irq_o;

  edge_detect_multi #(.WIDTH(4), .SYNC_STAGES(2), .FILT_CYCLES(FILT)) dut (
    .clk(clk), .reset_n(reset_n), .a_i(a_i), .mode_i(mode_i), .clear_i(clear_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .pending_o(pending_o),
    .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [3:0] m_sync0, m_sync1, m_level, m_rise, m_fall, m_pend;
  int         m_run [4];
  int         cnt_rise [4];
  int         cnt_fall [4];
  int         m_rise_cnt [4];
  int         m_fall_cnt [4];
  int         last_edge [4];
  bit         props_on = 1'b0;
  logic [16:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync0 = '0; m_sync1 = '0; m_level = '0;
    m_rise  = '0; m_fall  = '0; m_pend  = '0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({level_o, rise_o, fall_o, pending_o, irq_o}), 32'd0);
  endtask

  task automatic tick();
    logic [3:0]  ev, np, tg;
    logic [16:0] exp;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      ev = (m_rise & {mode_i[6], mode_i[4], mode_i[2], mode_i[0]}) |
           (m_fall & {mode_i[7], mode_i[5], mode_i[3], mode_i[1]});
      np = (m_pend & ~clear_i) | ev;
      tg = '0;
      for (int k = 0; k < 4; k++) begin
        if (m_sync1[k] != m_level[k]) begin
          if (m_run[k] == FILT - 1) begin tg[k] = 1'b1; m_run[k] = 0; end
          else m_run[k]++;
        end else m_run[k] = 0;
      end
      m_rise  = tg & ~m_level;
      m_fall  = tg & m_level;
      m_level = m_level ^ tg;
      m_pend  = np;
      m_sync1 = m_sync0;
      m_sync0 = a_i;
    end
    for (int k = 0; k < 4; k++) begin
      if (m_rise[k]) m_rise_cnt[k]++;
      if (m_fall[k]) m_fall_cnt[k]++;
    end
    sb_q.push_back({m_level, m_rise, m_fall, m_pend, |m_pend});
    @(negedge clk);
    cyc++;
    exp = sb_q.pop_front();
    check("scoreboard", 32'({level_o, rise_o, fall_o, pending_o, irq_o}), 32'(exp));
    for (int k = 0; k < 4; k++) begin
      if (rise_o[k]) cnt_rise[k]++;
      if (fall_o[k]) cnt_fall[k]++;
    end
    if (props_on) begin
      check("no_overlap", 32'(rise_o & fall_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
        if (rise_o[k] | fall_o[k]) begin
          if (last_edge[k] >= 0) check("edge_spacing", 32'(cyc - last_edge[k] >= FILT), 32'd1);
          last_edge[k] = cyc;
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("reset_immediate");
  endtask

  int r0, f0, fs;

  initial begin
    for (int k = 0; k < 4; k++) begin
      cnt_rise[k] = 0; cnt_fall[k] = 0; m_rise_cnt[k] = 0; m_fall_cnt[k] = 0; last_edge[k] = -1;
    end
    a_i = 4'h0; mode_i = 8'hFF; clear_i = 4'h0;
    assert_reset();
    ticks(2);
    reset_n = 1'b1;
    check_all_zero("reset_state");

    // 1: basic rise latency
    a_i[0] = 1'b1;
    ticks(5);
    check("t1_level_before_6", 32'(level_o[0]), 32'd0);
    tick();
    check("t1_level_edge6", 32'(level_o), 32'h1);
    check("t1_rise_edge6", 32'(rise_o), 32'h1);
    tick();
    check("t1_rise_one_cycle", 32'(rise_o), 32'h0);
    check("t1_pending", 32'(pending_o), 32'h1);
    check("t1_irq", 32'(irq_o), 32'd1);

    // 2: glitch rejection then accepted pulse
    r0 = cnt_rise[1]; f0 = cnt_fall[1];
    a_i[1] = 1'b1; ticks(3); a_i[1] = 1'b0; ticks(10);
    check("t2_glitch_rise", 32'(cnt_rise[1] - r0), 32'd0);
    check("t2_glitch_level", 32'(level_o[1]), 32'd0);
    check("t2_glitch_pend", 32'(pending_o[1]), 32'd0);
    a_i[1] = 1'b1; ticks(4); a_i[1] = 1'b0; ticks(12);
    check("t2_pulse_rise", 32'(cnt_rise[1] - r0), 32'd1);
    check("t2_pulse_fall", 32'(cnt_fall[1] - f0), 32'd1);

    // 3: per-channel event modes on channel 2
    clear_i = 4'hF; tick(); clear_i = 4'h0;
    check("t3_cleared", 32'(pending_o), 32'h0);
    mode_i = 8'b11_01_11_11;
    f0 = cnt_fall[2];
    a_i[2] = 1'b1; ticks(8);
    check("t3_rise_mode_set", 32'(pending_o[2]), 32'd1);
    clear_i[2] = 1'b1; a_i[2] = 1'b0; tick(); clear_i = 4'h0; ticks(11);
    check("t3_rise_mode_fall_seen", 32'(cnt_fall[2] - f0), 32'd1);
    check("t3_rise_mode_no_fall_set", 32'(pending_o[2]), 32'd0);
    mode_i = 8'b11_10_11_11;
    a_i[2] = 1'b1; ticks(10);
    check("t3_fall_mode_no_rise_set", 32'(pending_o[2]), 32'd0);
    a_i[2] = 1'b0; ticks(10);
    check("t3_fall_mode_set", 32'(pending_o[2]), 32'd1);
    mode_i = 8'b11_00_11_11; tick();
    check("t3_off_keeps_pending", 32'(pending_o[2]), 32'd1);
    clear_i[2] = 1'b1; tick(); clear_i = 4'h0;
    r0 = cnt_rise[2]; f0 = cnt_fall[2];
    a_i[2] = 1'b1; ticks(10); a_i[2] = 1'b0; ticks(10);
    check("t3_off_edges", 32'(cnt_rise[2] - r0 + cnt_fall[2] - f0), 32'd2);
    check("t3_off_no_set", 32'(pending_o[2]), 32'd0);

    // 4: set beats clear, then clear alone
    mode_i = 8'hFF;
    a_i[0] = 1'b0; ticks(6);
    check("t4_fall_edge6", 32'(fall_o), 32'h1);
    clear_i[0] = 1'b1; tick(); clear_i = 4'h0;
    check("t4_set_wins", 32'(pending_o[0]), 32'd1);
    check("t4_irq_set", 32'(irq_o), 32'd1);
    clear_i[0] = 1'b1; tick(); clear_i = 4'h0;
    check("t4_cleared", 32'(pending_o[0]), 32'd0);
    check("t4_irq_drop", 32'(irq_o), 32'd0);

    // 5: input high through reset, then reset mid-filter
    assert_reset();
    a_i = 4'hF; ticks(3);
    reset_n = 1'b1;
    ticks(5);
    check("t5_no_early_rise", 32'(rise_o), 32'h0);
    tick();
    check("t5_rise_all", 32'(rise_o), 32'hF);
    check("t5_level_all", 32'(level_o), 32'hF);
    a_i = 4'h0; ticks(3);
    assert_reset();
    ticks(2);
    reset_n = 1'b1;
    fs = 0; for (int k = 0; k < 4; k++) fs += cnt_fall[k];
    ticks(10);
    for (int k = 0; k < 4; k++) fs -= cnt_fall[k];
    check("t5_no_fall_after_reset", 32'(fs), 32'd0);
    check("t5_level_zero", 32'(level_o), 32'h0);

    // 6: random toggles with property checks
    props_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) a_i[k] = ~a_i[k];
      if (i % 50 == 0) mode_i = 8'($urandom());
      clear_i = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'h0;
      tick();
    end
    clear_i = 4'h0;
    ticks(10);
    for (int k = 0; k < 4; k++) begin
      check("t6_rise_count", 32'(cnt_rise[k]), 32'(m_rise_cnt[k]));
      check("t6_fall_count", 32'(cnt_fall[k]), 32'(m_fall_cnt[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
